// File: rtl/div_unit.sv
// div_unit -- iterative RV32M divider (DIV, DIVU, REM, REMU) for the execute stage.
// It uses radix-2 restoring division: one quotient bit per cycle, 32 RUN cycles.
// The two RV32M corner cases (divide by zero and signed overflow) skip RUN.
// Their result is registered directly in the start cycle.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   StartE     divide-class instruction present in E
//   DivOpE     00 DIV, 01 DIVU, 10 REM, 11 REMU
//   SrcAE      dividend (post-forwarding)
//   SrcBE      divisor (post-forwarding)
//   FlushE     abort current operation
//   DivStallE  stall request to hazard logic
//   DoneE      ResultE valid this cycle (one-cycle pulse)
//   ResultE    quotient or remainder, held until the next completion or reset
module div_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        StartE,
  input  logic [1:0]  DivOpE,
  input  logic [31:0] SrcAE,
  input  logic [31:0] SrcBE,
  input  logic        FlushE,
  output logic        DivStallE,
  output logic        DoneE,
  output logic [31:0] ResultE
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // Context latched at start. After the start cycle the unit never looks at
  // the E-stage operands again.
  typedef struct packed {
    logic [1:0] op;
    logic       qsign;
    logic       rsign;
  } div_ctx_t;

  state_t      state, state_nxt;
  div_ctx_t    ctx;
  logic [31:0] quo, rem, dvsr;
  logic [4:0]  cnt;

  // ---- start-cycle decode ----
  logic        sgn_op, div0, ovf, special, accept;
  logic [31:0] a_abs, b_abs, spec_res;

  always_comb begin
    sgn_op   = ~DivOpE[0];
    a_abs    = (sgn_op && SrcAE[31]) ? -SrcAE : SrcAE;
    b_abs    = (sgn_op && SrcBE[31]) ? -SrcBE : SrcBE;
    div0     = (SrcBE == 32'h0);
    ovf      = sgn_op && (SrcAE == 32'h8000_0000) && (SrcBE == 32'hFFFF_FFFF);
    special  = div0 | ovf;
    if (div0) spec_res = DivOpE[1] ? SrcAE : 32'hFFFF_FFFF;
    else      spec_res = DivOpE[1] ? 32'h0 : 32'h8000_0000;
    accept   = (state == IDLE) && StartE && !FlushE;
  end

  // ---- one restoring step ----
  // The shifted partial remainder can reach 33 bits, so the compare uses 33 bits.
  // When the subtraction is kept, the true difference is below the divisor.
  // Its low 32 bits are therefore exact.
  logic [32:0] shl;
  logic [31:0] diff, rem_nxt, quo_nxt, fin_rem, fin_quo, fin;
  logic        take, last;

  always_comb begin
    shl     = {rem, quo[31]};
    take    = (shl >= {1'b0, dvsr});
    diff    = shl[31:0] - dvsr;
    rem_nxt = take ? diff : shl[31:0];
    quo_nxt = {quo[30:0], take};
    fin_rem = ctx.rsign ? -rem_nxt : rem_nxt;
    fin_quo = ctx.qsign ? -quo_nxt : quo_nxt;
    fin     = ctx.op[1] ? fin_rem : fin_quo;
    last    = (cnt == 5'd31);
  end

  // ---- FSM ----
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    DivStallE = 1'b0;
    DoneE     = 1'b0;
    case (state)
      IDLE: begin
        DivStallE = StartE;
        if (StartE && !FlushE) state_nxt = special ? DONE : RUN;
      end
      RUN: begin
        DivStallE = 1'b1;
        if (FlushE)    state_nxt = IDLE;
        else if (last) state_nxt = DONE;
      end
      DONE: begin
        // StartE here still belongs to the completing instruction.
        DoneE     = !FlushE;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (rst) begin
      state_nxt = IDLE;
      DivStallE = 1'b0;
      DoneE     = 1'b0;
    end
  end

  // ---- datapath ----
  always_ff @(posedge clk) begin
    if (rst) begin
      ctx     <= '0;
      quo     <= '0;
      rem     <= '0;
      dvsr    <= '0;
      cnt     <= '0;
      ResultE <= '0;
    end else if (accept) begin
      ctx.op    <= DivOpE;
      ctx.qsign <= sgn_op & (SrcAE[31] ^ SrcBE[31]);
      ctx.rsign <= sgn_op & SrcAE[31];
      quo       <= a_abs;
      dvsr      <= b_abs;
      rem       <= '0;
      cnt       <= '0;
      if (special) ResultE <= spec_res;
    end else if (state == RUN && !FlushE) begin
      rem <= rem_nxt;
      quo <= quo_nxt;
      cnt <= cnt + 5'd1;
      if (last) ResultE <= fin;
    end
  end

endmodule

// File: tb/tb_div_unit.sv
module tb_div_unit;
  logic        clk = 1'b0;
  logic        rst, StartE, FlushE;
  logic [1:0]  DivOpE;
  logic [31:0] SrcAE, SrcBE;
  logic        DivStallE, DoneE;
  logic [31:0] ResultE;

  int checks = 0;
  int errors = 0;

  div_unit dut (
    .clk(clk), .rst(rst), .StartE(StartE), .DivOpE(DivOpE),
    .SrcAE(SrcAE), .SrcBE(SrcBE), .FlushE(FlushE),
    .DivStallE(DivStallE), .DoneE(DoneE), .ResultE(ResultE)
  );

  always #5 clk = ~clk;

  localparam logic [1:0] DIV = 2'b00, DIVU = 2'b01, REM = 2'b10, REMU = 2'b11;

  // Reference: RV32M semantics with plain arithmetic. SV's / and % truncate toward zero.
  function automatic logic [31:0] model(logic [1:0] op, logic [31:0] a, logic [31:0] b);
    int sa, sb;
    if (b == 0) return op[1] ? a : 32'hFFFF_FFFF;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
      return op[1] ? 32'h0 : 32'h8000_0000;
    if (!op[0]) begin
      sa = a; sb = b;
      return op[1] ? 32'(sa % sb) : 32'(sa / sb);
    end
    return op[1] ? a % b : a / b;
  endfunction

  function automatic bit is_special(logic [1:0] op, logic [31:0] a, logic [31:0] b);
    return (b == 0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called just after a negedge. The cycle of the call is T0.
  // StartE stays high until DoneE, as it would with a stalled E stage.
  // The task returns just after the negedge that follows the done cycle.
  task automatic do_op(string tag, logic [1:0] op, logic [31:0] a, logic [31:0] b);
    int stalls = 0;
    int cyc    = 0;
    bit done   = 0;
    logic [31:0] exp = model(op, a, b);
    int explat = is_special(op, a, b) ? 1 : 33;
    StartE = 1'b1; DivOpE = op; SrcAE = a; SrcBE = b;
    while (!done && cyc < 40) begin
      #1;
      if (DoneE) begin
        done = 1;
        chk({tag, "_lat"}, cyc, explat);
        chk({tag, "_res"}, ResultE, exp);
        chk({tag, "_stalls"}, stalls, explat);
        chk({tag, "_nostall_done"}, {31'b0, DivStallE}, 32'd0);
      end else begin
        if (DivStallE) stalls++;
        cyc++;
      end
      @(negedge clk);
    end
    chk({tag, "_finished"}, {31'b0, done}, 32'd1);
  endtask

  initial begin
    logic [31:0] held;
    logic [1:0]  rop;
    logic [31:0] ra, rb;
    rst = 1'b1; StartE = 1'b1; FlushE = 1'b0; DivOpE = DIVU;
    SrcAE = 32'd100; SrcBE = 32'd7;

    // Reset state
    @(negedge clk); #1;
    chk("rst_stall", {31'b0, DivStallE}, 32'd0);
    chk("rst_done", {31'b0, DoneE}, 32'd0);
    chk("rst_result", ResultE, 32'd0);
    @(negedge clk);
    rst = 1'b0; StartE = 1'b0;

    // Directed cases
    do_op("divu", DIVU, 32'd100, 32'd7);
    do_op("remu", REMU, 32'd100, 32'd7);
    do_op("rem_neg", REM, 32'hFFFF_FFF9, 32'd2);
    do_op("div_neg", DIV, 32'hFFFF_FFF9, 32'd2);
    do_op("div_by0", DIV, 32'h1234_5678, 32'd0);
    do_op("remu_by0", REMU, 32'h1234_5678, 32'd0);
    do_op("div_ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    do_op("rem_ovf", REM, 32'h8000_0000, 32'hFFFF_FFFF);
    do_op("divu_max", DIVU, 32'hFFFF_FFFF, 32'd1);
    do_op("rem_negdiv", REM, 32'd7, 32'hFFFF_FFFE);

    // The done cycle must be a single pulse
    StartE = 1'b0; #1;
    chk("done_pulse", {31'b0, DoneE}, 32'd0);

    // Flush mid-operation: the old result stays and no DoneE is produced
    held = ResultE;
    @(negedge clk);
    StartE = 1'b1; DivOpE = DIVU; SrcAE = 32'd1000; SrcBE = 32'd3;
    repeat (10) @(negedge clk);
    FlushE = 1'b1;
    @(negedge clk);
    FlushE = 1'b0; StartE = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("flush_done", {31'b0, DoneE}, 32'd0);
      chk("flush_stall", {31'b0, DivStallE}, 32'd0);
      chk("flush_hold", ResultE, held);
      @(negedge clk);
    end
    do_op("after_flush", DIVU, 32'd9, 32'd3);

    // Reset mid-operation
    StartE = 1'b1; DivOpE = DIVU; SrcAE = 32'd100; SrcBE = 32'd7;
    repeat (5) @(negedge clk);
    rst = 1'b1; #1;
    chk("mid_rst_stall", {31'b0, DivStallE}, 32'd0);
    chk("mid_rst_done", {31'b0, DoneE}, 32'd0);
    @(negedge clk);
    rst = 1'b0; StartE = 1'b0; #1;
    chk("mid_rst_result", ResultE, 32'd0);
    chk("mid_rst_idle", {31'b0, DivStallE}, 32'd0);
    @(negedge clk);
    do_op("after_rst", DIVU, 32'd100, 32'd7);

    // Randomized ops, issued back-to-back
    for (int n = 0; n < 40; n++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: rb = 32'($urandom_range(1, 15));
        3: rb = -32'($urandom_range(1, 15));
        default: rb = $urandom;
      endcase
      do_op("rand", rop, ra, rb);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
